microwave_timer_controller: RTL and testbench
=============================================

Name: microwave_timer_controller

Overview:
- Control unit for the microwave timer. Consumes the priority-encoded keypad digit (D, loadn) and the 1 Hz pulse produced by the timer input/control stage.
- Assembles a 4-digit BCD MM:SS preset and sequences the cook cycle: entry, run, pause, done.
- Counts the preset down once per second and drives the magnetron enable.
- Sits between the keypad/timer input stage and the display/actuator stage.

Parameters:
- TICK_IS_PULSE, 1, tick_1Hz is a one-clk-wide pulse (1) or a raw 1 Hz square wave to be rising-edge detected internally (0).

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- tick_1Hz  input  1  1 Hz timebase (see TICK_IS_PULSE)
- D  input  4  BCD digit from priority encoder
- loadn  input  1  active-low key-valid, held low while key pressed
- startn  input  1  active-low start button (level)
- stopn  input  1  active-low stop/pause button (level)
- clearn  input  1  active-low clear button (level)
- door_closed  input  1  1 = door closed
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD timer value
- magnetron_on  output  1  registered, 1 only in RUN
- done  output  1  1 while in DONE
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset: synchronous; applies on any clk edge with resetn=0, including mid-run. Result: state=IDLE, all digits 0, magnetron_on=0, done=0, edge detectors cleared.
- Digit entry:
  - Falling edge of loadn is detected internally (registered previous value); one digit per key press regardless of hold time.
  - Entry is accepted only in IDLE and only when D<=9; D>9 is ignored.
  - Accepted digit shifts the display left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - The result is visible 1 cycle after the registered edge. A fifth digit discards min_tens.
- nonzero = any digit != 0.
- Input priority, highest first: resetn, door open, stopn, clearn, startn.
- IDLE:
  - clearn=0 -> digits <= 0, stay IDLE.
  - startn=0 & door_closed & nonzero -> RUN next cycle. A start with zero time or door open is ignored.
- RUN:
  - door_closed=0 or stopn=0 -> PAUSE; no decrement that cycle, even if a tick coincides.
  - Tick with no pause condition -> decrement one second:
    - sec_ones>0: sec_ones-1.
    - else sec_tens>0: sec_tens-1, sec_ones=9.
    - else min_ones>0: min_ones-1, sec_tens=5, sec_ones=9.
    - else min_tens-1, min_ones=9, sec_tens=5, sec_ones=9.
  - Preset sec_tens values >5 (e.g. 00:75) count down without normalisation.
  - If the decrement produces 00:00, the same edge moves the state to DONE.
  - startn and clearn are ignored in RUN.
  - The tick on the cycle of entering RUN is not counted.
- PAUSE:
  - clearn=0 -> digits <= 0, IDLE.
  - Otherwise startn=0 & stopn=1 & door_closed -> RUN. The time is nonzero by construction.
  - Ticks are ignored.
- DONE:
  - Digits stay 00:00 and done=1.
  - clearn=0 or door_closed=0 -> IDLE. startn is ignored.
- magnetron_on and done are registered and decoded from the next state, so they change on the same edge as state.
- Simultaneous key edge and start in IDLE: start is evaluated against the pre-shift value; the digit is still accepted.

Test Plan:
- Reset, then keys 1,3,0 (loadn pulses 3 cycles low each) -> digits 01:30, state IDLE. A fourth key with D=12 -> unchanged.
- Preset 00:03, startn low 1 cycle, door closed -> RUN, magnetron_on=1. Three ticks -> 00:02, 00:01, then 00:00 with DONE/done=1 on the same edge.
- Preset 01:00, run, one tick -> 00:59. Preset 10:00, one tick -> 09:59.
- Running 00:10, door_closed=0 on the same cycle as a tick -> PAUSE, still 00:10, magnetron_on=0. Door closed + startn -> RUN, next tick -> 00:09.
- PAUSE then clearn -> IDLE, 00:00. startn with 00:00 -> stays IDLE.
- RUN at 00:05, resetn=0 for 1 cycle -> IDLE, 00:00, magnetron_on=0 on the next edge.

Source files
------------

// File: rtl/microwave_timer_controller.sv
// Microwave timer control unit: BCD MM:SS preset entry, cook-cycle sequencing
// (IDLE/RUN/PAUSE/DONE), once-per-second countdown and magnetron enable.
module microwave_timer_controller #(
    parameter bit TICK_IS_PULSE = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick_1Hz,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [1:0] state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
    logic       magnetron_on_q, magnetron_on_d;
    logic       done_q, done_d;
    logic       loadn_prev_q, loadn_prev_d;
    logic       tick_prev_q, tick_prev_d;

    logic       key_edge, tick_evt, nonzero, pause_req, dec_zero;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

    assign key_edge  = loadn_prev_q & ~loadn;
    assign tick_evt  = TICK_IS_PULSE ? tick_1Hz : (tick_1Hz & ~tick_prev_q);
    assign nonzero   = |{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
    assign pause_req = ~door_closed | ~stopn;

    assign loadn_prev_d = loadn;
    assign tick_prev_d  = tick_1Hz;

    // One-second borrow chain; sec_tens above 5 is left as entered.
    always_comb begin
        dec_mt = min_tens_q;
        dec_mo = min_ones_q;
        dec_st = sec_tens_q;
        dec_so = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_so = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_st = sec_tens_q - 4'd1;
            dec_so = 4'd9;
        end else if (min_ones_q != 4'd0) begin
            dec_mo = min_ones_q - 4'd1;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end else begin
            dec_mt = min_tens_q - 4'd1;
            dec_mo = 4'd9;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end
    end

    assign dec_zero = ~|{dec_mt, dec_mo, dec_st, dec_so};

    // Digit datapath
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        unique case (state_q)
            S_IDLE: begin
                if (!clearn) begin
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
                end else if (key_edge && (D <= 4'd9)) begin
                    min_tens_d = min_ones_q;
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = D;
                end
            end
            S_RUN: begin
                if (!pause_req && tick_evt) begin
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} =
                        {dec_mt, dec_mo, dec_st, dec_so};
                end
            end
            S_PAUSE: begin
                if (!clearn) begin
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic; start in IDLE sees the pre-shift digits.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clearn && !startn && stopn && door_closed && nonzero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pause_req) begin
                    state_d = S_PAUSE;
                end else if (tick_evt && dec_zero) begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (!clearn) begin
                    state_d = S_IDLE;
                end else if (!startn && stopn && door_closed) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (!clearn || !door_closed) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs decoded from the next state so they switch with the state flop.
    always_comb begin
        magnetron_on_d = (state_d == S_RUN);
        done_d         = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            min_tens_q     <= 4'd0;
            min_ones_q     <= 4'd0;
            sec_tens_q     <= 4'd0;
            sec_ones_q     <= 4'd0;
            magnetron_on_q <= 1'b0;
            done_q         <= 1'b0;
            loadn_prev_q   <= 1'b1;
            tick_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            min_tens_q     <= min_tens_d;
            min_ones_q     <= min_ones_d;
            sec_tens_q     <= sec_tens_d;
            sec_ones_q     <= sec_ones_d;
            magnetron_on_q <= magnetron_on_d;
            done_q         <= done_d;
            loadn_prev_q   <= loadn_prev_d;
            tick_prev_q    <= tick_prev_d;
        end
    end

    assign min_tens     = min_tens_q;
    assign min_ones     = min_ones_q;
    assign sec_tens     = sec_tens_q;
    assign sec_ones     = sec_ones_q;
    assign magnetron_on = magnetron_on_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_microwave_timer_controller.sv
// Directed bench for microwave_timer_controller: the driver queues the expected
// {digits, state, magnetron_on, done} after each action; a monitor compares.
module tb_microwave_timer_controller;

    localparam int W = 20;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic       clk;
    logic       resetn;
    logic       tick_1Hz;
    logic [3:0] D;
    logic       loadn, startn, stopn, clearn, door_closed;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       magnetron_on, done;
    logic [1:0] state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           passes = 0;

    microwave_timer_controller #(.TICK_IS_PULSE(1'b1)) dut (
        .clk(clk), .resetn(resetn), .tick_1Hz(tick_1Hz), .D(D), .loadn(loadn),
        .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .magnetron_on(magnetron_on), .done(done), .state(state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares the DUT outputs on the falling edge against the queue head
    always @(negedge clk) begin
        logic [W-1:0] exp_v, act_v;
        string nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {min_tens, min_ones, sec_tens, sec_ones, state, magnetron_on, done};
            checks++;
            if (act_v === exp_v) passes++;
            else $display("FAIL %s: got digits=%h state=%b mag=%b done=%b, expected digits=%h state=%b mag=%b done=%b",
                          nm, act_v[19:4], act_v[3:2], act_v[1], act_v[0],
                          exp_v[19:4], exp_v[3:2], exp_v[1], exp_v[0]);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] dig,
                              input logic [1:0] st, input logic mag, input logic dn);
        exp_q.push_back({dig, st, mag, dn});
        name_q.push_back(nm);
    endtask

    task automatic key(input logic [3:0] d);
        D = d;
        loadn = 1'b0;
        repeat (3) step();
        loadn = 1'b1;
        step();
    endtask

    task automatic press_start();
        startn = 1'b0;
        step();
        startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step();
        stopn = 1'b1;
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    task automatic tick();
        tick_1Hz = 1'b1;
        step();
        tick_1Hz = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; tick_1Hz = 1'b0; D = 4'd0; loadn = 1'b1;
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
        repeat (2) step();
        expect_out("reset", 16'h0000, S_IDLE, 1'b0, 1'b0);
        resetn = 1'b1;
        step();

        // Digit entry and invalid digit
        key(4'd1); expect_out("key1", 16'h0001, S_IDLE, 1'b0, 1'b0);
        key(4'd3); expect_out("key3", 16'h0013, S_IDLE, 1'b0, 1'b0);
        key(4'd0); expect_out("key0", 16'h0130, S_IDLE, 1'b0, 1'b0);
        key(4'd12); expect_out("key_gt9", 16'h0130, S_IDLE, 1'b0, 1'b0);
        press_clear(); expect_out("idle_clear", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // 00:03 countdown to DONE, door-open start ignored
        key(4'd0); key(4'd3); expect_out("preset_0003", 16'h0003, S_IDLE, 1'b0, 1'b0);
        door_closed = 1'b0;
        press_start(); expect_out("start_door_open", 16'h0003, S_IDLE, 1'b0, 1'b0);
        door_closed = 1'b1;
        press_start(); expect_out("start_0003", 16'h0003, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0002", 16'h0002, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0001", 16'h0001, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_done", 16'h0000, S_DONE, 1'b0, 1'b1);
        press_start(); expect_out("done_start_ign", 16'h0000, S_DONE, 1'b0, 1'b1);
        press_clear(); expect_out("done_clear", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // Minute borrow: 01:00 -> 00:59
        key(4'd1); key(4'd0); key(4'd0);
        press_start(); expect_out("start_0100", 16'h0100, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0059", 16'h0059, S_RUN, 1'b1, 1'b0);
        press_stop(); expect_out("stop_0059", 16'h0059, S_PAUSE, 1'b0, 1'b0);
        press_clear(); expect_out("pause_clear1", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // Ten-minute borrow: 10:00 -> 09:59
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        press_start(); expect_out("start_1000", 16'h1000, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0959", 16'h0959, S_RUN, 1'b1, 1'b0);
        press_stop(); press_clear(); expect_out("pause_clear2", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // Door opens on a tick cycle: pause wins, no decrement
        key(4'd1); key(4'd0);
        press_start(); expect_out("start_0010", 16'h0010, S_RUN, 1'b1, 1'b0);
        door_closed = 1'b0; tick_1Hz = 1'b1;
        step();
        tick_1Hz = 1'b0;
        expect_out("door_open_tick", 16'h0010, S_PAUSE, 1'b0, 1'b0);
        tick(); expect_out("pause_tick_ign", 16'h0010, S_PAUSE, 1'b0, 1'b0);
        door_closed = 1'b1;
        press_start(); expect_out("resume", 16'h0010, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0009", 16'h0009, S_RUN, 1'b1, 1'b0);
        press_stop(); press_clear(); expect_out("pause_clear3", 16'h0000, S_IDLE, 1'b0, 1'b0);
        press_start(); expect_out("start_zero_ign", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // Reset mid-run
        key(4'd5);
        press_start(); expect_out("start_0005", 16'h0005, S_RUN, 1'b1, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        expect_out("reset_midrun", 16'h0000, S_IDLE, 1'b0, 1'b0);

        // Key edge with start on zero time: start rejected, digit accepted
        D = 4'd5; loadn = 1'b0; startn = 1'b0;
        step();
        startn = 1'b1;
        repeat (2) step();
        loadn = 1'b1;
        step();
        expect_out("key_and_start", 16'h0005, S_IDLE, 1'b0, 1'b0);
        tick(); expect_out("idle_tick_ign", 16'h0005, S_IDLE, 1'b0, 1'b0);
        press_clear();

        // Fifth digit drops min_tens
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        expect_out("four_digits", 16'h1234, S_IDLE, 1'b0, 1'b0);
        key(4'd5); expect_out("fifth_digit", 16'h2345, S_IDLE, 1'b0, 1'b0);
        press_clear();

        // Unnormalised seconds 00:75
        key(4'd7); key(4'd5);
        press_start(); expect_out("start_0075", 16'h0075, S_RUN, 1'b1, 1'b0);
        tick(); expect_out("tick_0074", 16'h0074, S_RUN, 1'b1, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
